// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode, execute,
// memory and write-back over several cycles with a req/ready memory handshake.
module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ILLEGAL_HALT  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       branch_neg,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWRITE = 4'd4,
        MEMWB    = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic       branch;
        logic       trap;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   ready;
    logic   in_fetch;
    logic   pc_update;
    logic   branch_taken;

    // Moore control word of a state; it is registered together with the state
    // so the outputs come straight from flops.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
            MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            EXEC_R:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            EXEC_I:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            ALUWB:    c.reg_write = 1'b1;
            BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
            JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            ILLEGAL:  c.trap = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXEC_R;
                    OP_I:              state_next = EXEC_I;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    default:           state_next = ILLEGAL;
                endcase
            end
            MEMADR:   state_next = opcode[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = ready ? MEMWB : MEMREAD;
            MEMWRITE: state_next = ready ? FETCH : MEMWRITE;
            EXEC_R, EXEC_I, JAL: state_next = ALUWB;
            ILLEGAL:  state_next = ILLEGAL_HALT ? ILLEGAL : FETCH;
            default:  state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ctrl  <= decode(FETCH);
        end else begin
            state <= state_next;
            ctrl  <= decode(state_next);
        end
    end

    // Handshake-completion terms depend on mem_ready in the same cycle.
    assign in_fetch     = (state == FETCH);
    assign pc_update    = (in_fetch & ready) | (state == JAL);
    assign branch_taken = ctrl.branch & (alu_zero == branch_neg);

    // Everything is gated by rst_n so a reset mid-access drops requests at once.
    assign mem_req    = rst_n & ctrl.mem_req;
    assign mem_write  = rst_n & ctrl.mem_write;
    assign adr_src    = rst_n & ctrl.adr_src;
    assign reg_write  = rst_n & ctrl.reg_write;
    assign trap       = rst_n & ctrl.trap;
    assign ir_write   = rst_n & in_fetch & ready;
    assign pc_write   = rst_n & (pc_update | branch_taken);
    assign retire     = rst_n & ((state == MEMWB) | (state == ALUWB) | (state == BRANCH) |
                                 ((state == MEMWRITE) & ready));
    assign alu_src_a  = rst_n ? ctrl.alu_src_a  : 2'b00;
    assign alu_src_b  = rst_n ? ctrl.alu_src_b  : 2'b00;
    assign alu_op     = rst_n ? ctrl.alu_op     : 2'b00;
    assign result_src = rst_n ? ctrl.result_src : 2'b00;
    assign state_dbg  = state;

    always_comb begin
        imm_src = 2'b00;
        if (rst_n) begin
            case (opcode)
                OP_STORE:  imm_src = 2'b01;
                OP_BRANCH: imm_src = 2'b10;
                OP_JAL:    imm_src = 2'b11;
                default:   imm_src = 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed literal sequences plus
// randomized instruction streams checked against a per-instruction step table.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       alu_zero = 1'b0;
    logic       branch_neg = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic [3:0] state_dbg;
    logic       n_mem_req, n_mem_write, n_adr_src, n_ir_write, n_pc_write, n_reg_write, n_retire, n_trap;
    logic [1:0] n_alu_src_a, n_alu_src_b, n_alu_op, n_result_src, n_imm_src;
    logic [3:0] n_state_dbg;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .branch_neg(branch_neg),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
        .retire(retire), .trap(trap), .state_dbg(state_dbg)
    );

    multicycle_controller #(.MEM_HANDSHAKE(1'b0), .ILLEGAL_HALT(1'b0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .branch_neg(branch_neg),
        .mem_ready(mem_ready), .mem_req(n_mem_req), .mem_write(n_mem_write), .adr_src(n_adr_src),
        .ir_write(n_ir_write), .pc_write(n_pc_write), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
        .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .result_src(n_result_src), .imm_src(n_imm_src),
        .retire(n_retire), .trap(n_trap), .state_dbg(n_state_dbg)
    );

    always #5 clk = ~clk;

    // Field order: req wr adr | irw pcw rgw | srcA | srcB | alu_op | result_src | retire trap
    logic [15:0] o1, o2;
    assign o1 = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, alu_op, result_src, retire, trap};
    assign o2 = {n_mem_req, n_mem_write, n_adr_src, n_ir_write, n_pc_write, n_reg_write,
                 n_alu_src_a, n_alu_src_b, n_alu_op, n_result_src, n_retire, n_trap};

    localparam logic [15:0] FETCHW = 16'b100_110_00_10_00_10_00;
    localparam logic [15:0] FETCH0 = 16'b100_000_00_10_00_10_00;
    localparam logic [15:0] DEC    = 16'b000_000_01_01_00_00_00;
    localparam logic [15:0] EXR    = 16'b000_000_10_00_10_00_00;
    localparam logic [15:0] EXI    = 16'b000_000_10_01_10_00_00;
    localparam logic [15:0] AWB    = 16'b000_001_00_00_00_00_10;
    localparam logic [15:0] MADR   = 16'b000_000_10_01_00_00_00;
    localparam logic [15:0] MRD    = 16'b101_000_00_00_00_00_00;
    localparam logic [15:0] MWB    = 16'b000_001_00_00_00_01_10;
    localparam logic [15:0] MWR    = 16'b111_000_00_00_00_00_00;
    localparam logic [15:0] BRN    = 16'b000_000_10_00_01_00_10;
    localparam logic [15:0] JALV   = 16'b000_010_01_10_00_00_00;
    localparam logic [15:0] ILL    = 16'b000_000_00_00_00_00_01;
    localparam logic [15:0] IRW    = 16'h1000;
    localparam logic [15:0] PCW    = 16'h0800;
    localparam logic [15:0] RET    = 16'h0002;

    typedef struct {
        logic [15:0] base;
        bit          stall;  // repeats while mem_ready is low
        bit          fetch;  // ir_write/pc_write when mem_ready is high
        bit          rret;   // retire when mem_ready is high
        bit          br;     // pc_write when alu_zero == branch_neg
    } step_t;

    int n_chk = 0;
    int n_fail = 0;
    logic [3:0] last_sd1, last_sd2, fetch_code, ill_code;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Called at posedge+1: drive inputs, check at negedge, advance to posedge+1.
    task automatic cyc(input logic rdy, input logic az, input logic bn, input string nm,
                       input logic [15:0] exp);
        mem_ready = rdy; alu_zero = az; branch_neg = bn;
        @(negedge clk);
        chk(nm, o1, exp);
        last_sd1 = state_dbg;
        @(posedge clk); #1;
    endtask

    task automatic cyc2(input logic rdy, input string nm, input logic [15:0] e1, input logic [15:0] e2);
        mem_ready = rdy;
        @(negedge clk);
        chk(nm, o1, e1);
        chk({nm, "_nh"}, o2, e2);
        last_sd1 = state_dbg;
        last_sd2 = n_state_dbg;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        opcode = 7'b0100011;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("reset_outputs", o1, 16'h0000);
        chk("reset_imm_src", {14'd0, imm_src}, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    function automatic step_t mkst(input logic [15:0] b, input bit s, input bit f, input bit r, input bit br);
        step_t t;
        t.base = b; t.stall = s; t.fetch = f; t.rret = r; t.br = br;
        return t;
    endfunction

    initial begin
        logic [6:0] opc [6];
        step_t q[$];
        int k, idx;
        logic rdy, az, bn;
        logic [15:0] exp;
        opc = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

        do_reset();

        // add x3,x1,x2
        opcode = 7'b0110011;
        cyc(1'b1, 1'b0, 1'b0, "add_fetch", FETCHW);
        fetch_code = last_sd1;
        cyc(1'b1, 1'b0, 1'b0, "add_decode", DEC);
        cyc(1'b1, 1'b0, 1'b0, "add_exec", EXR);
        cyc(1'b1, 1'b0, 1'b0, "add_wb", AWB);

        // lw with three stall cycles in MEMREAD; mem_ready low elsewhere is ignored
        opcode = 7'b0000011;
        cyc(1'b1, 1'b0, 1'b0, "lw_fetch", FETCHW);
        cyc(1'b0, 1'b0, 1'b0, "lw_decode", DEC);
        cyc(1'b0, 1'b0, 1'b0, "lw_memadr", MADR);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, "lw_memread_wait", MRD);
        cyc(1'b1, 1'b0, 1'b0, "lw_memread_done", MRD);
        cyc(1'b0, 1'b0, 1'b0, "lw_memwb", MWB);
        cyc(1'b0, 1'b0, 1'b0, "lw_next_fetch_stall", FETCH0);

        // beq taken, blt not taken
        opcode = 7'b1100011;
        cyc(1'b1, 1'b0, 1'b0, "beq_fetch", FETCHW);
        cyc(1'b1, 1'b0, 1'b0, "beq_decode", DEC);
        cyc(1'b1, 1'b1, 1'b1, "beq_taken", BRN | PCW);
        cyc(1'b1, 1'b0, 1'b0, "blt_fetch", FETCHW);
        cyc(1'b1, 1'b0, 1'b0, "blt_decode", DEC);
        cyc(1'b1, 1'b1, 1'b0, "blt_not_taken", BRN);

        // jal
        opcode = 7'b1101111;
        cyc(1'b1, 1'b0, 1'b0, "jal_fetch", FETCHW);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("jal_imm_src", {14'd0, imm_src}, 16'h0003);
        @(posedge clk); #1;
        cyc(1'b1, 1'b0, 1'b0, "jal_jal", JALV);
        cyc(1'b1, 1'b0, 1'b0, "jal_aluwb", AWB);

        // Illegal opcode: halting instance vs. non-halting, handshake-free instance
        do_reset();
        opcode = 7'h7F;
        cyc2(1'b0, "ill_c1", FETCH0, FETCHW);
        cyc2(1'b1, "ill_c2", FETCHW, DEC);
        cyc2(1'b1, "ill_c3", DEC, ILL);
        ill_code = last_sd2;
        cyc2(1'b1, "ill_c4", ILL, FETCHW);
        chk("sdbg_fetch_nh", {12'd0, last_sd2}, {12'd0, fetch_code});
        chk("sdbg_ill", {12'd0, last_sd1}, {12'd0, ill_code});
        cyc2(1'b0, "ill_c5", ILL, DEC);
        cyc2(1'b0, "ill_c6", ILL, ILL);
        chk("ill_imm_src_nh", {14'd0, n_imm_src}, 16'h0000);

        // Reset while a store waits for mem_ready
        do_reset();
        opcode = 7'b0100011;
        cyc(1'b1, 1'b0, 1'b0, "sw_fetch", FETCHW);
        cyc(1'b1, 1'b0, 1'b0, "sw_decode", DEC);
        cyc(1'b1, 1'b0, 1'b0, "sw_memadr", MADR);
        cyc(1'b0, 1'b0, 1'b0, "sw_memwrite_wait", MWR);
        #2 rst_n = 1'b0;
        #1 chk("sw_reset_drop", o1, 16'h0000);
        @(negedge clk);
        chk("sw_reset_hold", o1, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "sw_after_reset", FETCH0);
        chk("sdbg_after_reset", {12'd0, last_sd1}, {12'd0, fetch_code});

        // Randomized instruction stream against the step table
        do_reset();
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 5);
            opcode = opc[k];
            q = {mkst(FETCH0, 1'b1, 1'b1, 1'b0, 1'b0), mkst(DEC, 1'b0, 1'b0, 1'b0, 1'b0)};
            case (k)
                0: begin
                    q.push_back(mkst(MADR, 1'b0, 1'b0, 1'b0, 1'b0));
                    q.push_back(mkst(MRD, 1'b1, 1'b0, 1'b0, 1'b0));
                    q.push_back(mkst(MWB, 1'b0, 1'b0, 1'b0, 1'b0));
                end
                1: begin
                    q.push_back(mkst(MADR, 1'b0, 1'b0, 1'b0, 1'b0));
                    q.push_back(mkst(MWR, 1'b1, 1'b0, 1'b1, 1'b0));
                end
                2: begin
                    q.push_back(mkst(EXR, 1'b0, 1'b0, 1'b0, 1'b0));
                    q.push_back(mkst(AWB, 1'b0, 1'b0, 1'b0, 1'b0));
                end
                3: begin
                    q.push_back(mkst(EXI, 1'b0, 1'b0, 1'b0, 1'b0));
                    q.push_back(mkst(AWB, 1'b0, 1'b0, 1'b0, 1'b0));
                end
                4: q.push_back(mkst(BRN, 1'b0, 1'b0, 1'b0, 1'b1));
                default: begin
                    q.push_back(mkst(JALV, 1'b0, 1'b0, 1'b0, 1'b0));
                    q.push_back(mkst(AWB, 1'b0, 1'b0, 1'b0, 1'b0));
                end
            endcase
            idx = 0;
            while (idx < q.size()) begin
                rdy = ($urandom_range(0, 3) != 0);
                az = 1'($urandom_range(0, 1));
                bn = 1'($urandom_range(0, 1));
                mem_ready = rdy; alu_zero = az; branch_neg = bn;
                exp = q[idx].base;
                if (q[idx].fetch && rdy) exp = exp | IRW | PCW;
                if (q[idx].rret && rdy) exp = exp | RET;
                if (q[idx].br && (az == bn)) exp = exp | PCW;
                @(negedge clk);
                chk("rand_outputs", o1, exp);
                chk("rand_imm_src", {14'd0, imm_src}, {14'd0, imm_of(opcode)});
                if (!(q[idx].stall && !rdy)) idx++;
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
